// File: rtl/bp_pht_ctrl_if.sv
// Branch-resolution update channel from execute into the PHT write controller.
// The execute side (master) offers an update; the controller (slave) accepts
// it on any edge where upd_valid and upd_ready are both high.
interface bp_pht_ctrl_if #(
    parameter int ADDR_W  = 10,
    parameter int STATE_W = 2
);
    logic               upd_valid;
    logic               upd_ready;
    logic [ADDR_W-1:0]  upd_addr;
    logic [STATE_W-1:0] upd_state;
    logic               upd_taken;

    modport master (
        output upd_valid,
        output upd_addr,
        output upd_state,
        output upd_taken,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_addr,
        input  upd_state,
        input  upd_taken,
        output upd_ready
    );
endinterface

// File: rtl/bp_pht_ctrl.sv
// Pattern-history-table write controller.
// Sweeps the whole table to INIT_STATE after reset and on flush_req, then
// turns resolved-branch updates into saturating-counter writes buffered in a
// QDEPTH-entry FIFO, issuing at most one PHT write per cycle.
// Optional feature: define BP_PHT_UPD_BYPASS_EN to let an update accepted
// while the FIFO is empty go straight to the write bus (1-cycle latency).
module bp_pht_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int STATE_W    = 2,
    parameter int INIT_STATE = 1,
    parameter int QDEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush_req,
    bp_pht_ctrl_if.slave              upd,
    output logic [ADDR_W+STATE_W:0]   pht_wbus,
    output logic                      init_done,
    output logic                      busy
);

    localparam int ENT_W = ADDR_W + STATE_W;
    localparam int PTR_W = $clog2(QDEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ENT_W:0]     wbus_q, wbus_d;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]   fifo_mem [QDEPTH];

    logic               fifo_empty;
    logic               fifo_full;
    logic               accept;
    logic               push;
    logic [STATE_W-1:0] nxt;
    logic [ENT_W-1:0]   upd_entry;
    logic [ENT_W-1:0]   fifo_head;

    // FIFO occupancy flags from wrap-bit pointers
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        fifo_head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    end

    // Handshake and status outputs; a full FIFO refuses even if it pops this cycle
    always_comb begin
        upd.upd_ready = (state_q == ST_RUN) && !fifo_full && !flush_req;
        accept        = upd.upd_valid && upd.upd_ready;
        init_done     = (state_q == ST_RUN);
        busy          = (state_q == ST_INIT) || !fifo_empty;
        pht_wbus      = wbus_q;
    end

    // Saturating counter step, bounds tested before the add/subtract
    always_comb begin
        nxt = upd.upd_state;
        if (upd.upd_taken) begin
            if (upd.upd_state != '1) begin
                nxt = upd.upd_state + STATE_W'(1);
            end
        end else begin
            if (upd.upd_state != '0) begin
                nxt = upd.upd_state - STATE_W'(1);
            end
        end
        upd_entry = {upd.upd_addr, nxt};
    end

    // Next-state: init sweep, FIFO pop/push, flush override
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wbus_d   = {1'b0, wbus_q[ENT_W-1:0]};
        push     = 1'b0;

        if (flush_req) begin
            state_d  = ST_INIT;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else if (state_q == ST_INIT) begin
            wbus_d = {1'b1, cnt_q, STATE_W'(INIT_STATE)};
            cnt_d  = cnt_q + ADDR_W'(1);
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end else begin
            if (!fifo_empty) begin
                wbus_d   = {1'b1, fifo_head};
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            end
`ifdef BP_PHT_UPD_BYPASS_EN
            // Bypass only from an empty FIFO, so no queued write can be overtaken
            if (accept && fifo_empty) begin
                wbus_d = {1'b1, upd_entry};
            end else begin
                push = accept;
            end
`else
            push = accept;
`endif
            if (push) begin
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    // Control and write-bus registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            wbus_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wbus_q   <= wbus_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= upd_entry;
        end
    end

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Bench for bp_pht_ctrl with a 16-entry table: directed init/flush/reset
// scenarios plus random update traffic, checked against a queue-based model.
module tb_bp_pht_ctrl;

    localparam int ADDR_W     = 4;
    localparam int STATE_W    = 2;
    localparam int INIT_STATE = 1;
    localparam int QDEPTH     = 4;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int SMAX       = (1 << STATE_W) - 1;
    localparam int BUS_W      = 1 + ADDR_W + STATE_W;

    logic              clk;
    logic              resetn;
    logic              flush_req;
    logic [BUS_W-1:0]  pht_wbus;
    logic              init_done;
    logic              busy;

    bp_pht_ctrl_if #(.ADDR_W(ADDR_W), .STATE_W(STATE_W)) u_if ();

    bp_pht_ctrl #(
        .ADDR_W     (ADDR_W),
        .STATE_W    (STATE_W),
        .INIT_STATE (INIT_STATE),
        .QDEPTH     (QDEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush_req (flush_req),
        .upd       (u_if),
        .pht_wbus  (pht_wbus),
        .init_done (init_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: operating mode, init sweep index, pending writes, bus
    bit                        m_run;
    int                        m_idx;
    logic [ADDR_W+STATE_W-1:0] m_q[$];
    logic [BUS_W-1:0]          m_bus;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_next(input int s, input bit taken);
        if (taken) return (s >= SMAX) ? SMAX : s + 1;
        return (s <= 0) ? 0 : s - 1;
    endfunction

    task automatic do_reset();
        resetn         = 1'b0;
        flush_req      = 1'b0;
        u_if.upd_valid = 1'b0;
        #1;
        m_run = 1'b0;
        m_idx = 0;
        m_q.delete();
        m_bus = '0;
        check("rst_wbus", pht_wbus, 0);
        check("rst_ready", u_if.upd_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 1);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic cycle(input bit fl, input bit v, input logic [ADDR_W-1:0] a,
                         input logic [STATE_W-1:0] s, input bit t);
        bit exp_ready;
        bit acc;
        bit was_empty;
        logic [ADDR_W+STATE_W-1:0] ent;
        flush_req      = fl;
        u_if.upd_valid = v;
        u_if.upd_addr  = a;
        u_if.upd_state = s;
        u_if.upd_taken = t;
        #1;
        exp_ready = m_run && (m_q.size() < QDEPTH) && !fl;
        check("upd_ready", u_if.upd_ready, exp_ready);
        check("init_done", init_done, m_run);
        check("busy", busy, !m_run || (m_q.size() > 0));
        acc = v && exp_ready;
        @(posedge clk);
        if (fl) begin
            m_q.delete();
            m_run = 1'b0;
            m_idx = 0;
            m_bus[BUS_W-1] = 1'b0;
        end else if (!m_run) begin
            m_bus = {1'b1, ADDR_W'(m_idx), STATE_W'(INIT_STATE)};
            if (m_idx == DEPTH - 1) m_run = 1'b1;
            m_idx++;
        end else begin
            was_empty = (m_q.size() == 0);
            if (!was_empty) m_bus = {1'b1, m_q.pop_front()};
            else            m_bus[BUS_W-1] = 1'b0;
            if (acc) begin
                ent = {a, STATE_W'(sat_next(int'(s), t))};
`ifdef BP_PHT_UPD_BYPASS_EN
                if (was_empty) m_bus = {1'b1, ent};
                else           m_q.push_back(ent);
`else
                m_q.push_back(ent);
`endif
            end
        end
        #1;
        check("pht_wbus", pht_wbus, m_bus);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        flush_req      = 1'b0;
        u_if.upd_valid = 1'b0;
        u_if.upd_addr  = '0;
        u_if.upd_state = '0;
        u_if.upd_taken = 1'b0;

        // Reset and full init sweep
        do_reset();
        idle(DEPTH);
        check("sweep_last", pht_wbus, {1'b1, 4'd15, 2'd1});
        check("sweep_done", init_done, 1);
        idle(2);

        // Saturation at both ends on the same index
        cycle(1'b0, 1'b1, 4'd5, 2'd3, 1'b1);
        cycle(1'b0, 1'b1, 4'd5, 2'd0, 1'b0);
        idle(3);
        check("sat_quiet", pht_wbus, {1'b0, 4'd5, 2'd0});

        // Back-to-back updates, mixed directions
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, ADDR_W'(i + 8), STATE_W'(i), i[0]);
        idle(3);

        // Flush with an update in flight, then the complete resweep
        cycle(1'b0, 1'b1, 4'd2, 2'd1, 1'b1);
        cycle(1'b1, 1'b1, 4'd3, 2'd2, 1'b1);
        idle(DEPTH + 2);

        // Flush partway through init restarts at address 0
        do_reset();
        idle(9);
        check("pre_flush_addr", pht_wbus, {1'b1, 4'd8, 2'd1});
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        check("restart_addr0", pht_wbus, {1'b1, 4'd0, 2'd1});
        idle(DEPTH);

        // Asynchronous reset mid-RUN with a pending update
        cycle(1'b0, 1'b1, 4'd7, 2'd2, 1'b1);
        do_reset();
        idle(DEPTH + 1);

        // Random traffic with occasional flushes and one mid-run reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 7),
                  ADDR_W'($urandom),
                  STATE_W'($urandom),
                  $urandom_range(0, 1) == 1);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
